// File: rtl/arith_share_arb.sv
// arith_share_arb: round-robin arbiter sharing one registered N-bit adder
// among R requesters. Results leave through a valid/ready output stage,
// tagged with the requester index. A saturating counter tracks accepted
// results whose carry-out was set.
module arith_share_arb #(
    parameter int N   = 4,
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_in,
    input  logic [R*N-1:0] a_in,
    input  logic [R*N-1:0] b_in,
    output logic [R-1:0]   gnt_out,
    input  logic           ready_in,
    output logic           valid_out,
    output logic [N-1:0]   sum_out,
    output logic           carry_out,
    output logic [IDW-1:0] id_out,
    output logic [7:0]     ovf_cnt_out
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_sum;
    logic           r_carry;
    logic [IDW-1:0] r_id;
    logic [7:0]     r_ovf_cnt;

    logic           w_valid;
    logic           w_slot_free;
    logic           w_accept;
    logic           w_grant;
    logic [IDW-1:0] w_gnt_idx;
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_b;
    logic [N:0]     w_add;
    logic [IDW-1:0] w_ptr_next;
    int             w_idx;

    assign w_valid     = (r_state == S_FULL);
    // The output slot can take a new result if it is empty or being drained now.
    assign w_slot_free = !w_valid || ready_in;
    assign w_accept    = w_valid && ready_in;

    // Round-robin search: first requester at or after the pointer, wrapping modulo R.
    always_comb begin
        w_grant   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        if (rst_n && w_slot_free) begin
            for (int k = 0; k < R; k++) begin
                w_idx = (int'(r_ptr) + k) % R;
                if (!w_grant && req_in[w_idx]) begin
                    w_grant   = 1'b1;
                    w_gnt_idx = IDW'(w_idx);
                end
            end
        end
    end

    // One-hot grant decode; all zero when no grant is issued.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_gnt
            assign gnt_out[gi] = w_grant && (w_gnt_idx == IDW'(gi));
        end
    endgenerate

    // The single shared adder, kept at full N+1 width so the carry survives.
    assign w_a   = a_in[w_gnt_idx*N +: N];
    assign w_b   = b_in[w_gnt_idx*N +: N];
    assign w_add = {1'b0, w_a} + {1'b0, w_b};

    assign w_ptr_next = (w_gnt_idx == IDW'(R - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Output-stage control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a grant always fills the slot; an accept without a grant empties it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_grant) begin
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (w_grant) begin
                    w_state_next = S_FULL;
                end else if (ready_in) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Result register and priority pointer; both move only on a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_grant) begin
            r_sum   <= w_add[N-1:0];
            r_carry <= w_add[N];
            r_id    <= w_gnt_idx;
            r_ptr   <= w_ptr_next;
        end
    end

    // Saturating count of accepted results that carried out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_accept && r_carry && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign valid_out   = w_valid;
    assign sum_out     = r_sum;
    assign carry_out   = r_carry;
    assign id_out      = r_id;
    assign ovf_cnt_out = r_ovf_cnt;

endmodule
